// File: rtl/nco_mc_pkg.sv
// Shared definitions for the multi-channel DPSK NCO: configuration selectors,
// quadrant encoding and a width helper for channel fields.
package nco_mc_pkg;

  // Configuration register selectors (cfg_sel); value 3 is a no-op
  localparam logic [1:0] CFG_INC = 2'd0;
  localparam logic [1:0] CFG_OFF = 2'd1;
  localparam logic [1:0] CFG_CLR = 2'd2;

  // Quadrant taken from the two phase MSBs
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  // Ceiling log2 with a floor of 1 so a single-channel build still has a channel bit
  function automatic int nco_clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nco_qw_lut.sv
// Registered quarter-wave sine ROM with two read ports, addressed with i and ~i
// so that one access yields both the sine and cosine magnitudes.
module nco_qw_lut #(
  parameter int RAW = 10,
  parameter int MPR = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [RAW-3:0] addr_a,
  input  logic [RAW-3:0] addr_b,
  output logic [MPR-2:0] mag_a,
  output logic [MPR-2:0] mag_b
);

  localparam int  DEPTH   = 1 << (RAW - 2);
  localparam real AMP     = (1 << (MPR - 1)) - 1;
  localparam real PI_HALF = 1.5707963267948966;

  logic [MPR-2:0] rom [DEPTH];
  logic [MPR-2:0] mag_a_q, mag_a_d;
  logic [MPR-2:0] mag_b_q, mag_b_d;

  // Sample points sit at bin centres so the i / ~i symmetry is exact
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real ANG = PI_HALF * (real'(k) + 0.5) / real'(DEPTH);
    localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign rom[k] = (MPR-1)'(VAL);
  end

  // Read both ports only when the pipeline advances, otherwise hold
  always_comb begin
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    if (en) begin
      mag_a_d = rom[addr_a];
      mag_b_d = rom[addr_b];
    end
  end

  // Read data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_a_q <= '0;
      mag_b_q <= '0;
    end else begin
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
    end
  end

  assign mag_a = mag_a_q;
  assign mag_b = mag_b_q;

endmodule

// File: rtl/nco_mc_dpsk.sv
// Time-multiplexed multi-channel NCO with per-channel increment, static phase
// offset and differential PSK phase stepping. One channel slot per enabled clock,
// four register stages from slot to quadrature sample.
module nco_mc_dpsk
  import nco_mc_pkg::*;
#(
  parameter int NC       = 4,
  parameter int APR      = 32,
  parameter int RAW      = 10,
  parameter int MPR      = 10,
  parameter int PSK_BITS = 2,
  // Derived from NC; not meant to be overridden
  parameter int LOG2NC   = nco_clog2(NC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    cfg_we,
  input  logic [LOG2NC-1:0]       cfg_ch,
  input  logic [1:0]              cfg_sel,
  input  logic [APR-1:0]          cfg_data,
  input  logic                    sym_we,
  input  logic [LOG2NC-1:0]       sym_ch,
  input  logic [PSK_BITS-1:0]     sym_d,
  output logic signed [MPR-1:0]   fsin_o,
  output logic signed [MPR-1:0]   fcos_o,
  output logic [LOG2NC-1:0]       out_ch,
  output logic                    out_valid
);

  localparam int                    CH_SPAN   = 1 << LOG2NC;
  localparam logic [CH_SPAN-1:0]    CH_OK     = CH_SPAN'((1 << NC) - 1);
  localparam logic [LOG2NC-1:0]     SLOT_LAST = LOG2NC'(NC - 1);

  // Per-channel state
  logic [APR-1:0]      acc_q [NC];
  logic [APR-1:0]      acc_d [NC];
  logic [APR-1:0]      inc_q [NC];
  logic [APR-1:0]      inc_d [NC];
  logic [APR-1:0]      off_q [NC];
  logic [APR-1:0]      off_d [NC];
  logic [PSK_BITS-1:0] sph_q [NC];
  logic [PSK_BITS-1:0] sph_d [NC];
  logic [LOG2NC-1:0]   slot_q, slot_d;

  // Pipeline stages
  logic [RAW-1:0]      p1_q, p1_d;
  logic                v1_q, v1_d;
  logic [LOG2NC-1:0]   ch1_q, ch1_d;
  quad_e               q2_q, q2_d;
  logic [RAW-3:0]      i2_q, i2_d;
  logic                v2_q, v2_d;
  logic [LOG2NC-1:0]   ch2_q, ch2_d;
  quad_e               q3_q, q3_d;
  logic                v3_q, v3_d;
  logic [LOG2NC-1:0]   ch3_q, ch3_d;
  logic signed [MPR-1:0] fsin_q, fsin_d;
  logic signed [MPR-1:0] fcos_q, fcos_d;
  logic [LOG2NC-1:0]   out_ch_q, out_ch_d;
  logic                out_valid_q, out_valid_d;

  logic [MPR-2:0]        mag_i, mag_ni;
  logic signed [MPR-1:0] pos_i, pos_ni;
  logic signed [MPR-1:0] sin_w, cos_w;

  nco_qw_lut #(
    .RAW (RAW),
    .MPR (MPR)
  ) u_lut (
    .clk    (clk),
    .reset  (reset),
    .en     (clken),
    .addr_a (i2_q),
    .addr_b (~i2_q),
    .mag_a  (mag_i),
    .mag_b  (mag_ni)
  );

  // Slot accumulate plus host writes; a clear is applied last so it beats the accumulate
  always_comb begin
    acc_d  = acc_q;
    inc_d  = inc_q;
    off_d  = off_q;
    sph_d  = sph_q;
    slot_d = slot_q;
    if (clken) begin
      acc_d[slot_q] = acc_q[slot_q] + inc_q[slot_q];
      slot_d        = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
    if (cfg_we && CH_OK[cfg_ch]) begin
      case (cfg_sel)
        CFG_INC: inc_d[cfg_ch] = cfg_data;
        CFG_OFF: off_d[cfg_ch] = cfg_data;
        CFG_CLR: begin
          acc_d[cfg_ch] = '0;
          sph_d[cfg_ch] = '0;
        end
        default: ;
      endcase
    end
    if (sym_we && CH_OK[sym_ch]) begin
      sph_d[sym_ch] = sph_d[sym_ch] + sym_d;
    end
  end

  // Apply quadrant symmetry to the two LUT magnitudes
  always_comb begin
    pos_i  = {1'b0, mag_i};
    pos_ni = {1'b0, mag_ni};
    sin_w  = pos_i;
    cos_w  = pos_ni;
    case (q3_q)
      QUAD_0: begin sin_w = pos_i;   cos_w = pos_ni;  end
      QUAD_1: begin sin_w = pos_ni;  cos_w = -pos_i;  end
      QUAD_2: begin sin_w = -pos_i;  cos_w = -pos_ni; end
      QUAD_3: begin sin_w = -pos_ni; cos_w = pos_i;   end
      default: ;
    endcase
  end

  // Advance every stage together on clken; only the top RAW phase bits are kept
  always_comb begin
    p1_d        = p1_q;
    v1_d        = v1_q;
    ch1_d       = ch1_q;
    q2_d        = q2_q;
    i2_d        = i2_q;
    v2_d        = v2_q;
    ch2_d       = ch2_q;
    q3_d        = q3_q;
    v3_d        = v3_q;
    ch3_d       = ch3_q;
    fsin_d      = fsin_q;
    fcos_d      = fcos_q;
    out_ch_d    = out_ch_q;
    out_valid_d = 1'b0;
    if (clken) begin
      p1_d  = RAW'((acc_q[slot_q] + off_q[slot_q]
                    + {sph_q[slot_q], {(APR-PSK_BITS){1'b0}}}) >> (APR - RAW));
      v1_d  = 1'b1;
      ch1_d = slot_q;
      q2_d  = quad_e'(p1_q[RAW-1 -: 2]);
      i2_d  = p1_q[RAW-3:0];
      v2_d  = v1_q;
      ch2_d = ch1_q;
      q3_d  = q2_q;
      v3_d  = v2_q;
      ch3_d = ch2_q;
      out_valid_d = v3_q;
      if (v3_q) begin
        fsin_d   = sin_w;
        fcos_d   = cos_w;
        out_ch_d = ch3_q;
      end
    end
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NC; c++) begin
        acc_q[c] <= '0;
        inc_q[c] <= '0;
        off_q[c] <= '0;
        sph_q[c] <= '0;
      end
      slot_q      <= '0;
      p1_q        <= '0;
      v1_q        <= 1'b0;
      ch1_q       <= '0;
      q2_q        <= QUAD_0;
      i2_q        <= '0;
      v2_q        <= 1'b0;
      ch2_q       <= '0;
      q3_q        <= QUAD_0;
      v3_q        <= 1'b0;
      ch3_q       <= '0;
      fsin_q      <= '0;
      fcos_q      <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      inc_q       <= inc_d;
      off_q       <= off_d;
      sph_q       <= sph_d;
      slot_q      <= slot_d;
      p1_q        <= p1_d;
      v1_q        <= v1_d;
      ch1_q       <= ch1_d;
      q2_q        <= q2_d;
      i2_q        <= i2_d;
      v2_q        <= v2_d;
      ch2_q       <= ch2_d;
      q3_q        <= q3_d;
      v3_q        <= v3_d;
      ch3_q       <= ch3_d;
      fsin_q      <= fsin_d;
      fcos_q      <= fcos_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fsin_o    = fsin_q;
  assign fcos_o    = fcos_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nco_mc_dpsk.sv
// Scoreboard bench for nco_mc_dpsk: a phase-level channel model predicts each
// sample from the ideal sine at the lookup-bin centre; a monitor pops and compares.
module tb_nco_mc_dpsk;
  import nco_mc_pkg::*;

  localparam int  NC       = 4;
  localparam int  APR      = 32;
  localparam int  RAW      = 10;
  localparam int  MPR      = 10;
  localparam int  PSK_BITS = 2;
  localparam int  LOG2NC   = 2;
  localparam int  LATENCY  = 3;
  localparam real PI       = 3.14159265358979323846;
  localparam real AMP      = 511.0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset    = 1'b1;
  logic                clken    = 1'b0;
  logic                cfg_we   = 1'b0;
  logic [LOG2NC-1:0]   cfg_ch   = '0;
  logic [1:0]          cfg_sel  = '0;
  logic [APR-1:0]      cfg_data = '0;
  logic                sym_we   = 1'b0;
  logic [LOG2NC-1:0]   sym_ch   = '0;
  logic [PSK_BITS-1:0] sym_d    = '0;
  logic signed [MPR-1:0] fsin_o, fcos_o;
  logic [LOG2NC-1:0]   out_ch;
  logic                out_valid;

  nco_mc_dpsk #(
    .NC (NC), .APR (APR), .RAW (RAW), .MPR (MPR), .PSK_BITS (PSK_BITS)
  ) dut (
    .clk (clk), .reset (reset), .clken (clken),
    .cfg_we (cfg_we), .cfg_ch (cfg_ch), .cfg_sel (cfg_sel), .cfg_data (cfg_data),
    .sym_we (sym_we), .sym_ch (sym_ch), .sym_d (sym_d),
    .fsin_o (fsin_o), .fcos_o (fcos_o), .out_ch (out_ch), .out_valid (out_valid)
  );

  typedef struct {
    int ch;
    int s;
    int c;
    int due;
  } exp_t;

  exp_t        sb[$];
  int          checks    = 0;
  int          failures  = 0;
  bit [31:0]   m_acc [NC];
  bit [31:0]   m_inc [NC];
  bit [31:0]   m_off [NC];
  int          m_sph [NC];
  int          m_slot    = 0;
  int          m_edges   = 0;
  int          mon_edges = 0;

  task automatic checkOutput(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Ideal sine/cosine sampled at the centre of the RAW-bit phase bin, rounded half away from zero
  function automatic int refSample(input bit [31:0] ph, input bit want_cos);
    real th, v;
    int  idx;
    idx = int'(ph >> (APR - RAW));
    th  = 2.0 * PI * (real'(idx) + 0.5) / real'(1 << RAW);
    v   = AMP * (want_cos ? $cos(th) : $sin(th));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Drive one cycle of inputs at the falling edge and advance the channel model
  task automatic applyStimulus(input bit rst, input bit en, input bit cwe,
                               input bit [1:0] csel, input bit [1:0] cch,
                               input bit [31:0] cdata, input bit swe,
                               input bit [1:0] sch, input bit [1:0] sd);
    int        c;
    bit [31:0] ph;
    exp_t      e;
    @(negedge clk);
    reset = rst; clken = en; cfg_we = cwe; cfg_sel = csel; cfg_ch = cch;
    cfg_data = cdata; sym_we = swe; sym_ch = sch; sym_d = sd;
    if (rst) begin
      for (int k = 0; k < NC; k++) begin
        m_acc[k] = 0; m_inc[k] = 0; m_off[k] = 0; m_sph[k] = 0;
      end
      m_slot = 0;
      sb.delete();
    end else begin
      if (en) begin
        c  = m_slot;
        ph = m_acc[c] + m_off[c] + (32'(m_sph[c]) << (APR - PSK_BITS));
        m_edges++;
        e.ch = c; e.s = refSample(ph, 1'b0); e.c = refSample(ph, 1'b1);
        e.due = m_edges + LATENCY;
        sb.push_back(e);
        m_acc[c] = m_acc[c] + m_inc[c];
        m_slot   = (m_slot + 1) % NC;
      end
      if (cwe && int'(cch) < NC) begin
        case (csel)
          CFG_INC: m_inc[cch] = cdata;
          CFG_OFF: m_off[cch] = cdata;
          CFG_CLR: begin m_acc[cch] = 0; m_sph[cch] = 0; end
          default: ;
        endcase
      end
      if (swe && int'(sch) < NC) m_sph[sch] = (m_sph[sch] + int'(sd)) % (1 << PSK_BITS);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: count enabled edges, pop on every valid sample and compare
  initial begin : monitor
    bit   en_now;
    exp_t e;
    forever begin
      @(posedge clk);
      en_now = clken && !reset;
      if (en_now) mon_edges++;
      #1;
      if (out_valid) begin
        checkOutput("valid_needs_clken", int'(en_now), 1);
        if (sb.size() == 0) begin
          checkOutput("unexpected_sample", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          checkOutput("out_ch", int'(out_ch), e.ch);
          checkOutput("fsin", int'(fsin_o), e.s);
          checkOutput("fcos", int'(fcos_o), e.c);
          checkOutput("latency_edge", mon_edges, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= mon_edges) begin
        checkOutput("missing_sample", int'(out_valid), 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_fsin", int'(fsin_o), 0);
    checkOutput("reset_fcos", int'(fcos_o), 0);
    checkOutput("reset_out_ch", int'(out_ch), 0);

    // All-zero configuration
    idle(12);

    // Channel 0 quarter-turn per slot
    applyStimulus(0, 1, 1, CFG_INC, 0, 32'h4000_0000, 0, 0, 0);
    idle(20);

    // DQPSK steps on channel 1, one per channel period, wrapping back to zero
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 1);
      idle(3);
    end
    idle(8);

    // Clear on channel 2 landing on its own slot
    applyStimulus(0, 1, 1, CFG_INC, 2, 32'h1000_0000, 0, 0, 0);
    applyStimulus(0, 1, 1, CFG_OFF, 2, 32'h8000_0000, 0, 0, 0);
    idle(5);
    for (int k = 0; k < NC && m_slot != 2; k++) idle(1);
    applyStimulus(0, 1, 1, CFG_CLR, 2, 32'hdead_beef, 0, 0, 0);
    idle(8);

    // Clear and symbol on the same channel together
    applyStimulus(0, 1, 1, CFG_CLR, 3, 0, 1, 3, 2);
    idle(8);

    // Stalls with channel 0 still stepping
    for (int k = 0; k < 60; k++)
      applyStimulus(0, $urandom_range(0, 3) != 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // One-cycle reset mid-stream
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(10);

    // Fully random traffic
    for (int k = 0; k < 400; k++) begin
      applyStimulus(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom(),
                    $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)));
    end

    // Steady run; exactly the in-flight samples remain
    idle(4);
    @(posedge clk);
    #2;
    checkOutput("pending_after_drain", sb.size(), LATENCY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
